// File: rtl/pockel_pkg.sv
// Shared types and constants for the rectangle scene sequencer: FSM states,
// rectangle entry layout, panel defaults and the bounce step helper.
package pockel_pkg;

  typedef enum logic [2:0] {
    ST_DELAY,
    ST_INIT,
    ST_DRAW,
    ST_NEXT,
    ST_MOVE
  } state_t;

  typedef struct packed {
    logic [15:0] color;
    logic [15:0] xoff0;
    logic [15:0] xoff1;
    logic [15:0] yoff0;
    logic [15:0] yoff1;
  } rect_entry_t;

  typedef struct packed {
    logic        dir;
    logic [15:0] pos;
  } axis_t;

  localparam int          RECT_W       = 80;
  localparam int          DEF_SCREEN_W = 240;
  localparam int          DEF_SCREEN_H = 320;
  localparam logic [15:0] START_POS    = 16'd10;

  // dir=0 moves toward lim, dir=1 toward zero; the clamp and the reversal
  // happen together so the position never leaves [0, lim].
  function automatic axis_t axis_step(input axis_t cur, input logic [15:0] lim,
                                      input logic [15:0] step);
    axis_t nxt;
    nxt = cur;
    if (!cur.dir) begin
      if (({1'b0, cur.pos} + {1'b0, step}) >= {1'b0, lim}) begin
        nxt.pos = lim;
        nxt.dir = 1'b1;
      end else begin
        nxt.pos = cur.pos + step;
      end
    end else begin
      if (cur.pos <= step) begin
        nxt.pos = '0;
        nxt.dir = 1'b0;
      end else begin
        nxt.pos = cur.pos - step;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rect_table.sv
// Rectangle table: NUM_RECTS entries of {valid, 80-bit entry}, one synchronous
// write port and one combinational read port.
module rect_table
  import pockel_pkg::*;
#(
  parameter int NUM_RECTS = 4,
  parameter int AW        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_idx,
  input  logic [RECT_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  input  logic [AW-1:0]     i_rd_idx,
  output logic [RECT_W-1:0] o_rd_data,
  output logic              o_rd_valid
);

  logic [RECT_W:0] r_mem [NUM_RECTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en && (32'(i_wr_idx) < NUM_RECTS)) begin
      r_mem[i_wr_idx] <= {i_wr_valid, i_wr_data};
    end
  end

  always_comb begin
    o_rd_data  = '0;
    o_rd_valid = 1'b0;
    if (32'(i_rd_idx) < NUM_RECTS) begin
      o_rd_valid = r_mem[i_rd_idx][RECT_W];
      o_rd_data  = r_mem[i_rd_idx][RECT_W-1:0];
    end
  end

endmodule

// File: rtl/rect_scene_seq.sv
// Rectangle scene sequencer: after a power-up delay and panel init, draws every
// enabled table entry per frame at a bouncing group origin.
//
// state | meaning
// DELAY | power-up wait of 2^DLY_W cycles
// INIT  | tft_init issued, waiting for panel tft_done
// NEXT  | scan for next enabled entry, or end the frame
// DRAW  | tft_draw held until tft_done
// MOVE  | advance group origin (held while pause)
module rect_scene_seq
  import pockel_pkg::*;
#(
  parameter int NUM_RECTS = 4,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int GROUP_W   = 90,
  parameter int GROUP_H   = 160,
  parameter int STEP      = 1,
  parameter int DLY_W     = 16,
  localparam int AW       = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [79:0]   wr_data,
  input  logic          wr_valid_bit,
  input  logic          pause,
  output logic          tft_init,
  output logic          tft_draw,
  input  logic          tft_done,
  input  logic          tft_busy,
  output logic [15:0]   color,
  output logic [15:0]   xstart,
  output logic [15:0]   xend,
  output logic [15:0]   ystart,
  output logic [15:0]   yend,
  output logic          frame_done,
  output logic [15:0]   xpos,
  output logic [15:0]   ypos
);

  localparam int          IW     = AW + 1;
  localparam logic [15:0] XMAX   = 16'(SCREEN_W - GROUP_W - 1);
  localparam logic [15:0] YMAX   = 16'(SCREEN_H - GROUP_H - 1);
  localparam logic [15:0] STEP_V = 16'(STEP);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DLY_W-1:0]  r_cnt;
  logic [DLY_W-1:0]  w_cnt_nxt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [15:0]       r_xpos;
  logic [15:0]       w_xpos_nxt;
  logic [15:0]       r_ypos;
  logic [15:0]       w_ypos_nxt;
  logic              r_xdir;
  logic              w_xdir_nxt;
  logic              r_ydir;
  logic              w_ydir_nxt;
  logic              r_tft_init;
  logic              w_tft_init_nxt;
  logic              r_tft_draw;
  logic              w_tft_draw_nxt;
  logic              r_frame_done;
  logic              w_frame_done_nxt;
  logic [15:0]       r_color;
  logic [15:0]       w_color_nxt;
  logic [15:0]       r_xstart;
  logic [15:0]       w_xstart_nxt;
  logic [15:0]       r_xend;
  logic [15:0]       w_xend_nxt;
  logic [15:0]       r_ystart;
  logic [15:0]       w_ystart_nxt;
  logic [15:0]       r_yend;
  logic [15:0]       w_yend_nxt;

  logic [RECT_W-1:0] w_rd_data;
  logic              w_rd_valid;
  rect_entry_t       w_entry;
  axis_t             w_xstep;
  axis_t             w_ystep;
  logic              w_last;
  logic              w_unused_busy;

  rect_table #(
    .NUM_RECTS (NUM_RECTS),
    .AW        (AW)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wr_en),
    .i_wr_idx   (wr_idx),
    .i_wr_data  (wr_data),
    .i_wr_valid (wr_valid_bit),
    .i_rd_idx   (r_idx[AW-1:0]),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (w_rd_valid)
  );

  assign w_entry       = rect_entry_t'(w_rd_data);
  assign w_xstep       = axis_step({r_xdir, r_xpos}, XMAX, STEP_V);
  assign w_ystep       = axis_step({r_ydir, r_ypos}, YMAX, STEP_V);
  assign w_last        = (r_idx == IW'(NUM_RECTS));
  assign w_unused_busy = tft_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_DELAY;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_xpos       <= '0;
      r_ypos       <= '0;
      r_xdir       <= 1'b0;
      r_ydir       <= 1'b0;
      r_tft_init   <= 1'b0;
      r_tft_draw   <= 1'b0;
      r_frame_done <= 1'b0;
      r_color      <= '0;
      r_xstart     <= '0;
      r_xend       <= '0;
      r_ystart     <= '0;
      r_yend       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_xpos       <= w_xpos_nxt;
      r_ypos       <= w_ypos_nxt;
      r_xdir       <= w_xdir_nxt;
      r_ydir       <= w_ydir_nxt;
      r_tft_init   <= w_tft_init_nxt;
      r_tft_draw   <= w_tft_draw_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_color      <= w_color_nxt;
      r_xstart     <= w_xstart_nxt;
      r_xend       <= w_xend_nxt;
      r_ystart     <= w_ystart_nxt;
      r_yend       <= w_yend_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_xpos_nxt       = r_xpos;
    w_ypos_nxt       = r_ypos;
    w_xdir_nxt       = r_xdir;
    w_ydir_nxt       = r_ydir;
    w_tft_init_nxt   = 1'b0;
    w_tft_draw_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_color_nxt      = r_color;
    w_xstart_nxt     = r_xstart;
    w_xend_nxt       = r_xend;
    w_ystart_nxt     = r_ystart;
    w_yend_nxt       = r_yend;
    case (r_state)
      ST_DELAY: begin
        // down-counter wraps from 0, so terminal count 1 marks 2^DLY_W cycles
        w_cnt_nxt = r_cnt - DLY_W'(1);
        if (r_cnt == DLY_W'(1)) begin
          w_tft_init_nxt = 1'b1;
          w_state_nxt    = ST_INIT;
        end
      end
      ST_INIT: begin
        if (tft_done) begin
          w_xpos_nxt  = START_POS;
          w_ypos_nxt  = START_POS;
          w_xdir_nxt  = 1'b0;
          w_ydir_nxt  = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (w_last) begin
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = ST_MOVE;
        end else if (w_rd_valid) begin
          w_color_nxt    = w_entry.color;
          w_xstart_nxt   = r_xpos + w_entry.xoff0;
          w_xend_nxt     = r_xpos + w_entry.xoff1;
          w_ystart_nxt   = r_ypos + w_entry.yoff0;
          w_yend_nxt     = r_ypos + w_entry.yoff1;
          w_tft_draw_nxt = 1'b1;
          w_state_nxt    = ST_DRAW;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      ST_DRAW: begin
        if (tft_done) begin
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = ST_NEXT;
        end else begin
          w_tft_draw_nxt = 1'b1;
        end
      end
      ST_MOVE: begin
        if (!pause) begin
          w_xpos_nxt  = w_xstep.pos;
          w_xdir_nxt  = w_xstep.dir;
          w_ypos_nxt  = w_ystep.pos;
          w_ydir_nxt  = w_ystep.dir;
          w_idx_nxt   = '0;
          w_state_nxt = ST_NEXT;
        end
      end
      default: begin
        w_state_nxt = ST_DELAY;
      end
    endcase
  end

  assign tft_init   = r_tft_init;
  assign tft_draw   = r_tft_draw;
  assign frame_done = r_frame_done;
  assign color      = r_color;
  assign xstart     = r_xstart;
  assign xend       = r_xend;
  assign ystart     = r_ystart;
  assign yend       = r_yend;
  assign xpos       = r_xpos;
  assign ypos       = r_ypos;

endmodule

// File: tb/tb_rect_scene_seq.sv
// Directed bench for rect_scene_seq (STEP=4, DLY_W=4): startup, draw handshake,
// table skipping, pause, bounce limits and mid-draw reset.
module tb_rect_scene_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [79:0] wr_data;
  logic        wr_valid_bit;
  logic        pause;
  logic        tft_init;
  logic        tft_draw;
  logic        tft_done;
  logic        tft_busy;
  logic [15:0] color;
  logic [15:0] xstart;
  logic [15:0] xend;
  logic [15:0] ystart;
  logic [15:0] yend;
  logic        frame_done;
  logic [15:0] xpos;
  logic [15:0] ypos;

  int checks = 0;
  int errors = 0;
  int cyc;
  int n;
  int n_high;
  int draws = 0;
  int fd_cnt = 0;
  int fd_before;
  int draws_before;
  logic draw_q = 1'b0;

  always #5 clk = ~clk;

  rect_scene_seq #(
    .NUM_RECTS (4),
    .STEP      (4),
    .DLY_W     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .wr_valid_bit (wr_valid_bit),
    .pause        (pause),
    .tft_init     (tft_init),
    .tft_draw     (tft_draw),
    .tft_done     (tft_done),
    .tft_busy     (tft_busy),
    .color        (color),
    .xstart       (xstart),
    .xend         (xend),
    .ystart       (ystart),
    .yend         (yend),
    .frame_done   (frame_done),
    .xpos         (xpos),
    .ypos         (ypos)
  );

  always @(posedge clk) begin
    draw_q <= tft_draw;
    if (tft_draw && !draw_q) draws <= draws + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [15:0] c, input logic [15:0] x0,
                    input logic [15:0] x1, input logic [15:0] y0, input logic [15:0] y1,
                    input logic v);
    wr_en        = 1'b1;
    wr_idx       = idx[1:0];
    wr_data      = {c, x0, x1, y0, y1};
    wr_valid_bit = v;
    @(negedge clk);
    cyc++;
    wr_en = 1'b0;
  endtask

  task automatic wait_draw(input int max);
    n = 0;
    while (tft_draw !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_draw", tft_draw, 1);
  endtask

  task automatic wait_fd(input int max);
    n = 0;
    while (frame_done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frame_done", frame_done, 1);
  endtask

  task automatic wait_xchange(input logic [15:0] old, input int max);
    n = 0;
    while (xpos === old && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_xchange", (xpos !== old), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_valid_bit = 1'b0;
    pause = 1'b0; tft_done = 1'b0; tft_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tft_init", tft_init, 0);
    chk("rst_tft_draw", tft_draw, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_xpos", xpos, 0);
    chk("rst_ypos", ypos, 0);
    chk("rst_color", color, 0);
    chk("rst_xstart", xstart, 0);
    chk("rst_yend", yend, 0);

    // startup: table loaded during DELAY, init pulse 16 cycles after release
    rst = 1'b0;
    cyc = 0;
    wr(0, 16'h7BE0, 16'd0, 16'd90, 16'd0, 16'd20, 1'b1);
    wr(1, 16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    wr(2, 16'hF800, 16'd5, 16'd15, 16'd100, 16'd140, 1'b1);
    wr(3, 16'h1234, 16'd7, 16'd8, 16'd9, 16'd10, 1'b0);
    while (tft_init !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("init_cycle", cyc, 16);
    chk("init_pulse", tft_init, 1);
    @(negedge clk);
    chk("init_single", tft_init, 0);
    chk("init_no_move", xpos, 0);

    tft_done = 1'b1;
    @(negedge clk);
    tft_done = 1'b0;
    chk("init_xpos", xpos, 10);
    chk("init_ypos", ypos, 10);
    chk("next_no_draw", tft_draw, 0);
    @(negedge clk);
    chk("first_draw", tft_draw, 1);
    chk("e0_color", color, 16'h7BE0);
    chk("e0_xstart", xstart, 10);
    chk("e0_xend", xend, 100);
    chk("e0_ystart", ystart, 10);
    chk("e0_yend", yend, 30);

    // hold draw 50 cycles; rewrite entry 0 mid-draw (affects next frame only)
    n_high = 0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        wr_en = 1'b1; wr_idx = 2'd0; wr_valid_bit = 1'b1;
        wr_data = {16'h001F, 16'd0, 16'd50, 16'd0, 16'd20};
      end else begin
        wr_en = 1'b0;
      end
      if (tft_draw === 1'b1) n_high++;
    end
    chk("draw_held", n_high, 50);
    chk("draw_color_stable", color, 16'h7BE0);
    chk("draw_xend_stable", xend, 100);

    pause = 1'b1;
    tft_done = 1'b1;
    @(negedge clk);
    tft_done = 1'b0;
    chk("draw_drop", tft_draw, 0);

    wait_draw(10);
    chk("e2_color", color, 16'hF800);
    chk("e2_xstart", xstart, 15);
    chk("e2_xend", xend, 25);
    chk("e2_ystart", ystart, 110);
    chk("e2_yend", yend, 150);
    tft_done = 1'b1;
    @(negedge clk);
    tft_done = 1'b0;

    wait_fd(10);
    chk("frame0_draws", draws, 2);

    // paused in MOVE, stray tft_done ignored
    repeat (2) @(negedge clk);
    tft_done = 1'b1;
    @(negedge clk);
    tft_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("pause_xpos", xpos, 10);
    chk("pause_ypos", ypos, 10);
    chk("pause_no_draw", tft_draw, 0);
    chk("frame_done_once", fd_cnt, 1);
    chk("pause_draws", draws, 2);

    pause = 1'b0;
    @(negedge clk);
    chk("move1_xpos", xpos, 14);
    chk("move1_ypos", ypos, 14);
    @(negedge clk);
    chk("f1_draw", tft_draw, 1);
    chk("f1_color", color, 16'h001F);
    chk("f1_xstart", xstart, 14);
    chk("f1_xend", xend, 64);
    chk("f1_ystart", ystart, 14);
    chk("f1_yend", yend, 34);

    // disable everything; frames run with no draws
    wr(0, 16'h0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    wr(2, 16'h0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    tft_done = 1'b1;
    @(negedge clk);
    tft_done = 1'b0;
    draws_before = draws;

    n = 0;
    while (xpos !== 16'd146 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_x146", xpos, 146);
    chk("reach_y146", ypos, 146);
    fd_before = fd_cnt;
    wait_xchange(16'd146, 20);
    chk("bounce_x149", xpos, 149);
    chk("bounce_y150", ypos, 150);
    chk("fd_per_frame", fd_cnt - fd_before, 1);
    wait_xchange(16'd149, 20);
    chk("frame_period", n, 6);
    chk("bounce_x145", xpos, 145);
    chk("bounce_y154", ypos, 154);
    wait_xchange(16'd145, 20);
    chk("y158", ypos, 158);
    wait_xchange(16'd141, 20);
    chk("x137", xpos, 137);
    chk("y_clamp159", ypos, 159);
    wait_xchange(16'd137, 20);
    chk("y155", ypos, 155);
    chk("no_draws_disabled", draws, draws_before);

    // reset in the middle of a draw
    wr(0, 16'h07E0, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    wait_draw(20);
    #2 rst = 1'b1;
    #1;
    chk("rst_draw_drop", tft_draw, 0);
    chk("rst_mid_xpos", xpos, 0);
    chk("rst_mid_ypos", ypos, 0);
    chk("rst_mid_color", color, 0);
    chk("rst_mid_xstart", xstart, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (tft_init !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("reinit_cycle", cyc, 16);
    @(negedge clk);
    tft_done = 1'b1;
    @(negedge clk);
    tft_done = 1'b0;
    chk("reinit_xpos", xpos, 10);
    draws_before = draws;
    wait_fd(10);
    chk("table_cleared", draws, draws_before);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
